// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operation/result handshake bundle for seq_alu
interface seq_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            alu_ctrl;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  illegal;

    // Upstream side: presents operations, consumes results
    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // ALU side
    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked execute-stage ALU with iterative shifts (SEQ_ALU_BARREL_SHIFT_EN: single-cycle shifts)
module seq_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input logic    clk,
    input logic    rst,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

`ifdef SEQ_ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t                state;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  illegal_q;
    logic [DATA_WIDTH-1:0] next_result;

    // Single-cycle result; in the iterative build shifts return src_a,
    // which is exactly the answer for the shamt==0 shortcut.
    function automatic logic [DATA_WIDTH-1:0] eval_op(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            OP_SLL:  r = a << b[SHAMT_WIDTH-1:0];
            OP_SRL:  r = a >> b[SHAMT_WIDTH-1:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[SHAMT_WIDTH-1:0]);
`else
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign next_result   = eval_op(bus.alu_ctrl, bus.src_a, bus.src_b);
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

`ifndef SEQ_ALU_BARREL_SHIFT_EN
    logic [DATA_WIDTH-1:0]  work;
    logic [SHAMT_WIDTH-1:0] count;
    logic [3:0]             shift_op;
    logic [DATA_WIDTH-1:0]  shifted;
    logic                   start_shift;

    // One-bit shift step of the working register
    always_comb begin
        shifted = work;
        case (shift_op)
            OP_SLL:  shifted = {work[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work[DATA_WIDTH-1:1]};
            default: shifted = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
        endcase
    end

    assign start_shift = (bus.alu_ctrl == OP_SLL || bus.alu_ctrl == OP_SRL ||
                          bus.alu_ctrl == OP_SRA) && (bus.src_b[SHAMT_WIDTH-1:0] != '0);
`endif

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            work        <= '0;
            count       <= '0;
            shift_op    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is implied here: state is IDLE and rst is low
                    if (bus.in_valid) begin
                        illegal_q <= (bus.alu_ctrl > OP_SRA);
`ifndef SEQ_ALU_BARREL_SHIFT_EN
                        if (start_shift) begin
                            work     <= bus.src_a;
                            count    <= bus.src_b[SHAMT_WIDTH-1:0];
                            shift_op <= bus.alu_ctrl;
                            state    <= SHIFT;
                        end else
`endif
                        begin
                            result_q    <= next_result;
                            zero_q      <= (next_result == '0);
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
`ifndef SEQ_ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    work  <= shifted;
                    count <= count - SHAMT_WIDTH'(1);
                    if (count == SHAMT_WIDTH'(1)) begin
                        result_q    <= shifted;
                        zero_q      <= (shifted == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
module tb_seq_alu;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    seq_alu_if #(.DATA_WIDTH(32)) bus ();

    seq_alu #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: results straight from the operation definitions
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: begin r = a << sh; lat = sh + 1; end
            4'd8: begin r = a >> sh; lat = sh + 1; end
            4'd9: begin r = $unsigned($signed(a) >>> sh); lat = sh + 1; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        if (BARREL) lat = 1;
    endfunction

    // Issue one op from a negedge, measure latency, check outputs, hold, drain
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                          input logic exp_i, input int exp_lat, input int hold);
        int w;
        int lat;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = op;
        bus.src_a    = a;
        bus.src_b    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid) check({name, " busy in_ready"}, 32'(bus.in_ready), 32'd0);
        end while (!bus.out_valid && lat < 100);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, " result"}, bus.result, exp_r);
        check({name, " zero"}, 32'(bus.zero), 32'(exp_z));
        check({name, " illegal"}, 32'(bus.illegal), 32'(exp_i));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_ctrl = 4'($urandom_range(0, 15));
            @(negedge clk);
            check({name, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, " hold result"}, bus.result, exp_r);
            check({name, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
        int          lat;

        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.src_a     = 32'd0;
        bus.src_b     = 32'd0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset zero", 32'(bus.zero), 32'd0);
        check("reset illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

        vecs.push_back('{"add_wrap", 4'd0, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{"slt_neg",  4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1});
        vecs.push_back('{"sltu_big", 4'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{"slt_pos",  4'd5, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{"sltu_sm",  4'd6, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1});
        vecs.push_back('{"sra_4",    4'd9, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0, 5});
        vecs.push_back('{"sll_0",    4'd7, 32'h0000_1234, 32'h20, 32'h0000_1234, 1'b0, 1'b0, 1});
        vecs.push_back('{"resv_c",   4'hC, 32'h1234_5678, 32'h9, 32'h0, 1'b1, 1'b1, 1});
        vecs.push_back('{"xor_clr",  4'd4, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1});
        vecs.push_back('{"srl_31",   4'd8, 32'hFFFF_FFFF, 32'd31, 32'h1, 1'b0, 1'b0, 32});
        vecs.push_back('{"sll_31",   4'd7, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32});
        vecs.push_back('{"sra_1",    4'd9, 32'h7FFF_FFFF, 32'd1, 32'h3FFF_FFFF, 1'b0, 1'b0, 2});
        vecs.push_back('{"srl_hi",   4'd8, 32'h8000_0000, 32'h25, 32'h0400_0000, 1'b0, 1'b0, 6});
        vecs.push_back('{"sub_neg",  4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{"and",      4'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, 1'b0, 1'b0, 1});
        vecs.push_back('{"or_zero",  4'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{"resv_f",   4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b1, 1});
        vecs.push_back('{"add",      4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1});

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero,
                   vecs[i].ill, BARREL ? 1 : vecs[i].lat, 0);

        // Backpressure: result held through 5 stalled cycles, new ops ignored
        run_op("sub_hold", 4'd1, 32'd7, 32'd3, 32'd4, 1'b0, 1'b0, 1, 5);

        // Reset in the middle of a 10-bit srl discards the operation
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 4'd8;
        bus.src_a    = 32'hDEAD_BEEF;
        bus.src_b    = 32'd10;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort in_ready during rst", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort in_ready after rst", 32'(bus.in_ready), 32'd1);
        repeat (12) @(negedge clk);
        check("abort no stale out_valid", 32'(bus.out_valid), 32'd0);

        // Randomised ops against the reference model
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
            model(op, a, b, r, ill, lat);
            run_op($sformatf("rand%0d op%0d", n, op), op, a, b, r, (r == 32'd0), ill, lat,
                   $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
